// File: rtl/circle_scheduler.sv
// Generic synchronous FIFO with a registered occupancy count; storage is not reset.
// Latency: a written entry is visible on rd_dat the cycle after the write.
// Backpressure: wr_rdy low when full; writes offered while full are ignored.
module fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       wr_vld,
  output logic                       wr_rdy,
  input  logic [WIDTH-1:0]           wr_dat,
  input  logic                       rd_en,
  output logic [WIDTH-1:0]           rd_dat,
  output logic [$clog2(DEPTH+1)-1:0] count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             push;
  logic             pop;

  assign wr_rdy = (count < CW'(DEPTH));
  assign push   = wr_vld && wr_rdy;
  assign pop    = rd_en && (count != '0);
  assign rd_dat = mem[rd_ptr];

  // Pointers wrap naturally, so DEPTH must be a power of two.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wr_dat;
  end
endmodule

// Queues circle commands, arbitrates between full-screen clear and the circle engine.
// Latency: command accepted into an idle, empty block -> eng_start two cycles later.
// Backpressure: cmd_ready low while 4 commands queued; circles run until eng_done.
module circle_scheduler (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [7:0] cmd_x,
  input  logic [6:0] cmd_y,
  input  logic [7:0] cmd_r,
  input  logic [2:0] cmd_colour,
  input  logic       clear_req,
  output logic       eng_start,
  input  logic       eng_done,
  output logic [7:0] eng_centre_x,
  output logic [6:0] eng_centre_y,
  output logic [7:0] eng_radius,
  output logic [2:0] eng_colour,
  input  logic [7:0] eng_vga_x,
  input  logic [6:0] eng_vga_y,
  input  logic [2:0] eng_vga_colour,
  input  logic       eng_vga_plot,
  output logic [7:0] vga_x,
  output logic [6:0] vga_y,
  output logic [2:0] vga_colour,
  output logic       vga_plot,
  output logic       busy,
  output logic [7:0] circles_done
);
  typedef struct packed {
    logic [7:0] x;
    logic [6:0] y;
    logic [7:0] r;
    logic [2:0] colour;
  } cmd_t;

  typedef enum logic [2:0] {IDLE, CLEAR, LOAD, RUN, RELEASE} state_t;

  state_t     state;
  state_t     state_nxt;
  cmd_t       cmd_dat;
  cmd_t       head_dat;
  logic [2:0] fifo_cnt;
  logic       pop;
  logic       clear_pend;
  logic [7:0] sweep_x;
  logic [6:0] sweep_y;
  logic       sweep_last;
  logic [7:0] hold_x;
  logic [6:0] hold_y;
  logic [2:0] hold_colour;

  assign cmd_dat    = {cmd_x, cmd_y, cmd_r, cmd_colour};
  assign sweep_last = (sweep_x == 8'd159) && (sweep_y == 7'd119);
  assign busy       = (state != IDLE);

  fifo #(.WIDTH($bits(cmd_t)), .DEPTH(4)) u_cmd_fifo (
    .clk    (clk),
    .rst_n  (rst_n),
    .wr_vld (cmd_valid),
    .wr_rdy (cmd_ready),
    .wr_dat (cmd_dat),
    .rd_en  (pop),
    .rd_dat (head_dat),
    .count  (fifo_cnt)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    pop       = 1'b0;
    eng_start = 1'b0;
    case (state)
      IDLE: begin
        if (clear_pend)           state_nxt = CLEAR;
        else if (fifo_cnt != '0)  state_nxt = LOAD;
      end
      CLEAR: begin
        if (sweep_last) state_nxt = IDLE;
      end
      LOAD: begin
        pop       = 1'b1;
        state_nxt = RUN;
      end
      RUN: begin
        eng_start = 1'b1;
        if (eng_done) state_nxt = RELEASE;
      end
      RELEASE: begin
        if (!eng_done) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Idle/load show the last pixel driven, with plot suppressed.
  always_comb begin
    vga_x      = hold_x;
    vga_y      = hold_y;
    vga_colour = hold_colour;
    vga_plot   = 1'b0;
    case (state)
      CLEAR: begin
        vga_x      = sweep_x;
        vga_y      = sweep_y;
        vga_colour = 3'd0;
        vga_plot   = 1'b1;
      end
      RUN, RELEASE: begin
        vga_x      = eng_vga_x;
        vga_y      = eng_vga_y;
        vga_colour = eng_vga_colour;
        vga_plot   = eng_vga_plot;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      clear_pend   <= 1'b0;
      sweep_x      <= '0;
      sweep_y      <= '0;
      eng_centre_x <= '0;
      eng_centre_y <= '0;
      eng_radius   <= '0;
      eng_colour   <= '0;
      circles_done <= '0;
      hold_x       <= '0;
      hold_y       <= '0;
      hold_colour  <= '0;
    end else begin
      // A request arriving mid-clear is already covered by the sweep in flight.
      if (clear_req && !clear_pend && (state != CLEAR))
        clear_pend <= 1'b1;
      else if ((state == CLEAR) && sweep_last)
        clear_pend <= 1'b0;

      if (state == CLEAR) begin
        if (sweep_x == 8'd159) begin
          sweep_x <= '0;
          sweep_y <= sweep_last ? 7'd0 : sweep_y + 7'd1;
        end else begin
          sweep_x <= sweep_x + 8'd1;
        end
      end

      if (pop) begin
        eng_centre_x <= head_dat.x;
        eng_centre_y <= head_dat.y;
        eng_radius   <= head_dat.r;
        eng_colour   <= head_dat.colour;
      end

      if ((state == RUN) && eng_done)
        circles_done <= circles_done + 8'd1;

      if ((state == CLEAR) || (state == RUN) || (state == RELEASE)) begin
        hold_x      <= vga_x;
        hold_y      <= vga_y;
        hold_colour <= vga_colour;
      end
    end
  end
endmodule

// File: tb/tb_circle_scheduler.sv
// Bench for circle_scheduler: command table, scoreboard of expected engine parameters,
// and hand-written clear / hold-done / reset sequences.
module tb_circle_scheduler;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic [7:0] cmd_x = '0;
  logic [6:0] cmd_y = '0;
  logic [7:0] cmd_r = '0;
  logic [2:0] cmd_colour = '0;
  logic       clear_req = 1'b0;
  logic       eng_start;
  logic       eng_done = 1'b0;
  logic [7:0] eng_centre_x;
  logic [6:0] eng_centre_y;
  logic [7:0] eng_radius;
  logic [2:0] eng_colour;
  logic [7:0] eng_vga_x = '0;
  logic [6:0] eng_vga_y = '0;
  logic [2:0] eng_vga_colour = '0;
  logic       eng_vga_plot = 1'b0;
  logic [7:0] vga_x;
  logic [6:0] vga_y;
  logic [2:0] vga_colour;
  logic       vga_plot;
  logic       busy;
  logic [7:0] circles_done;

  typedef struct {
    logic [7:0] x;
    logic [6:0] y;
    logic [7:0] r;
    logic [2:0] c;
  } cmd_t;

  typedef struct {
    cmd_t cmd;
    logic exp_rdy;
  } vec_t;

  cmd_t sb_q[$];
  vec_t vecs[5];
  int   checks = 0;
  int   errors = 0;
  int   exp_done = 0;

  circle_scheduler dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .cmd_valid      (cmd_valid),
    .cmd_ready      (cmd_ready),
    .cmd_x          (cmd_x),
    .cmd_y          (cmd_y),
    .cmd_r          (cmd_r),
    .cmd_colour     (cmd_colour),
    .clear_req      (clear_req),
    .eng_start      (eng_start),
    .eng_done       (eng_done),
    .eng_centre_x   (eng_centre_x),
    .eng_centre_y   (eng_centre_y),
    .eng_radius     (eng_radius),
    .eng_colour     (eng_colour),
    .eng_vga_x      (eng_vga_x),
    .eng_vga_y      (eng_vga_y),
    .eng_vga_colour (eng_vga_colour),
    .eng_vga_plot   (eng_vga_plot),
    .vga_x          (vga_x),
    .vga_y          (vga_y),
    .vga_colour     (vga_colour),
    .vga_plot       (vga_plot),
    .busy           (busy),
    .circles_done   (circles_done)
  );

  initial forever #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_cmd(input cmd_t c);
    cmd_valid  = 1'b1;
    cmd_x      = c.x;
    cmd_y      = c.y;
    cmd_r      = c.r;
    cmd_colour = c.c;
  endtask

  function automatic cmd_t mk(input logic [7:0] x, input logic [6:0] y,
                              input logic [7:0] r, input logic [2:0] c);
    cmd_t t;
    t.x = x; t.y = y; t.r = r; t.c = c;
    return t;
  endfunction

  task automatic push_one(input cmd_t c);
    drive_cmd(c);
    sb_q.push_back(c);
    step();
    cmd_valid = 1'b0;
  endtask

  // Step until eng_start, then compare parameters against the scoreboard head.
  task automatic expect_start(input string tag, input int budget);
    bit   ok;
    cmd_t e;
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      step();
      if (eng_start) begin
        ok = 1'b1;
        break;
      end
    end
    chk({tag, "_start"}, 32'(ok), 32'd1);
    chk({tag, "_sb_pending"}, 32'(sb_q.size() != 0), 32'd1);
    if (ok && sb_q.size() != 0) begin
      e = sb_q.pop_front();
      chk({tag, "_params"}, {6'd0, eng_centre_x, eng_centre_y, eng_radius, eng_colour},
          {6'd0, e.x, e.y, e.r, e.c});
    end
  endtask

  // Engine side of one circle: pixel pass-through, done held for 'hold' cycles.
  task automatic complete(input string tag, input int hold);
    eng_vga_x = 8'h33; eng_vga_y = 7'h21; eng_vga_colour = 3'd5; eng_vga_plot = 1'b1;
    #1;
    chk({tag, "_pass"}, {13'd0, vga_plot, vga_x, vga_y, vga_colour}, {13'd0, 1'b1, 8'h33, 7'h21, 3'd5});
    eng_done = 1'b1;
    step();
    exp_done = (exp_done + 1) % 256;
    chk({tag, "_done_cnt"}, 32'(circles_done), 32'(exp_done));
    chk({tag, "_rel_start"}, 32'(eng_start), 32'd0);
    for (int i = 1; i < hold; i++) begin
      step();
      chk({tag, "_hold"}, {22'd0, eng_start, busy, circles_done}, {22'd0, 1'b0, 1'b1, 8'(exp_done)});
    end
    eng_vga_plot = 1'b0;
    eng_done = 1'b0;
    step();
    chk({tag, "_idle"}, {13'd0, busy, vga_plot, vga_x}, {13'd0, 1'b0, 1'b0, 8'h33});
  endtask

  task automatic check_clear(input bit inject);
    int plots, bad, fx, fy, lx, ly, ex, ey;
    plots = 0; bad = 0; fx = -1; fy = -1; lx = -1; ly = -1; ex = 0; ey = 0;
    for (int i = 0; i < 19400; i++) begin
      step();
      clear_req = 1'b0;
      if (vga_plot) begin
        if (plots == 0) begin
          fx = int'(vga_x);
          fy = int'(vga_y);
        end
        if (int'(vga_x) != ex || int'(vga_y) != ey || vga_colour != 3'd0 || !busy || eng_start)
          bad++;
        lx = int'(vga_x);
        ly = int'(vga_y);
        plots++;
        ex++;
        if (ex == 160) begin
          ex = 0;
          ey++;
        end
        if (inject && plots == 100) clear_req = 1'b1;
      end else if (plots > 0) begin
        break;
      end
    end
    chk("clear_plots", plots, 19200);
    chk("clear_pixel_errs", bad, 0);
    chk("clear_first_x", fx, 0);
    chk("clear_first_y", fy, 0);
    chk("clear_last_x", lx, 159);
    chk("clear_last_y", ly, 119);
    chk("clear_end_busy", 32'(busy), 32'd0);
    if (inject) begin
      bad = 0;
      repeat (4) begin
        step();
        if (vga_plot || busy) bad++;
      end
      chk("clear_dropped_req", bad, 0);
    end
  endtask

  initial begin
    int   bad;
    bit   found;
    cmd_t a;
    vecs[0] = '{cmd: '{x: 8'd10,  y: 7'd11,  r: 8'd12, c: 3'd1}, exp_rdy: 1'b1};
    vecs[1] = '{cmd: '{x: 8'd150, y: 7'd100, r: 8'd5,  c: 3'd2}, exp_rdy: 1'b1};
    vecs[2] = '{cmd: '{x: 8'd0,   y: 7'd0,   r: 8'd255, c: 3'd7}, exp_rdy: 1'b1};
    vecs[3] = '{cmd: '{x: 8'd255, y: 7'd127, r: 8'd1,  c: 3'd4}, exp_rdy: 1'b1};
    vecs[4] = '{cmd: '{x: 8'd99,  y: 7'd98,  r: 8'd97, c: 3'd6}, exp_rdy: 1'b0};

    // Reset state
    rst_n = 1'b0;
    repeat (3) step();
    chk("rst_outputs", {14'd0, vga_plot, vga_x, vga_y, vga_colour, busy, eng_start, cmd_ready},
        {14'd0, 1'b0, 8'd0, 7'd0, 3'd0, 1'b0, 1'b0, 1'b1});
    rst_n = 1'b1;
    step();
    chk("rst_params", {6'd0, eng_centre_x, eng_centre_y, eng_radius, eng_colour}, 32'd0);
    chk("rst_count", 32'(circles_done), 32'd0);

    // Single command latency: accept at N, LOAD at N+1, eng_start from N+2
    push_one(mk(8'd80, 7'd60, 8'd10, 3'd3));
    chk("lat_n", {30'd0, eng_start, busy}, {30'd0, 1'b0, 1'b0});
    step();
    chk("lat_n1", {30'd0, eng_start, busy}, {30'd0, 1'b0, 1'b1});
    expect_start("single", 1);
    chk("single_cnt0", 32'(circles_done), 32'd0);
    complete("single", 1);

    // FIFO full behaviour while the engine is stalled on circle A
    a = mk(8'd1, 7'd2, 8'd3, 3'd1);
    push_one(a);
    expect_start("A", 4);
    for (int i = 0; i < 5; i++) begin
      drive_cmd(vecs[i].cmd);
      chk($sformatf("push%0d_rdy", i), 32'(cmd_ready), 32'(vecs[i].exp_rdy));
      if (vecs[i].exp_rdy) sb_q.push_back(vecs[i].cmd);
      step();
    end
    cmd_valid = 1'b0;
    chk("full_rdy", 32'(cmd_ready), 32'd0);
    chk("A_params_stable", {6'd0, eng_centre_x, eng_centre_y, eng_radius, eng_colour},
        {6'd0, a.x, a.y, a.r, a.c});
    complete("A", 1);
    for (int i = 0; i < 4; i++) begin
      expect_start($sformatf("q%0d", i), 6);
      complete($sformatf("q%0d", i), 1);
    end
    bad = 0;
    repeat (6) begin
      step();
      if (eng_start || busy) bad++;
    end
    chk("fifo_drained", bad, 0);

    // Clear from idle, with a redundant request mid-sweep
    clear_req = 1'b1;
    step();
    clear_req = 1'b0;
    chk("clear_pend_idle", {30'd0, busy, vga_plot}, 32'd0);
    check_clear(1'b1);

    // Clear requested during RUN with two circles queued
    push_one(mk(8'd40, 7'd30, 8'd20, 3'd2));
    expect_start("C1", 4);
    push_one(mk(8'd41, 7'd31, 8'd21, 3'd3));
    push_one(mk(8'd42, 7'd32, 8'd22, 3'd4));
    clear_req = 1'b1;
    step();
    clear_req = 1'b0;
    chk("C1_not_interrupted", {30'd0, eng_start, vga_plot}, {30'd0, 1'b1, 1'b0});
    complete("C1", 1);
    check_clear(1'b0);
    expect_start("C2", 5);
    complete("C2", 1);
    expect_start("C3", 5);
    complete("C3", 1);

    // eng_done held high: single increment, no restart
    push_one(mk(8'd7, 7'd8, 8'd9, 3'd5));
    expect_start("hold", 4);
    complete("hold", 4);

    // Reset mid-clear at pixel (50,20) with commands queued
    clear_req = 1'b1;
    step();
    clear_req = 1'b0;
    drive_cmd(mk(8'd11, 7'd12, 8'd13, 3'd1));
    step();
    step();
    cmd_valid = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 5000; i++) begin
      if (vga_plot && vga_x == 8'd50 && vga_y == 7'd20) begin
        found = 1'b1;
        break;
      end
      step();
    end
    chk("rst_found_50_20", 32'(found), 32'd1);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    exp_done = 0;
    chk("midclr_outputs", {14'd0, vga_plot, vga_x, vga_y, vga_colour, busy, eng_start, cmd_ready},
        {14'd0, 1'b0, 8'd0, 7'd0, 3'd0, 1'b0, 1'b0, 1'b1});
    chk("midclr_params", {6'd0, eng_centre_x, eng_centre_y, eng_radius, eng_colour}, 32'd0);
    chk("midclr_count", 32'(circles_done), 32'd0);
    bad = 0;
    repeat (40) begin
      step();
      if (vga_plot || busy || eng_start || !cmd_ready) bad++;
    end
    chk("midclr_quiet", bad, 0);
    chk("sb_all_seen", sb_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
